// File: rtl/pcie_dllp_decode.sv
// Receive-side PCIe DLLP decoder: frames 2-beat DLLPs, checks CRC-16 and drives Ack/Nak and FC-credit sideband.
// Optional CRC checking is enabled by defining DLLP_CRC_CHECK_EN; tready is high whenever out of reset.
module pcie_dllp_decode #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  phy_link_up_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [11:0]           seq_num_o,
  output logic                  seq_num_vld_o,
  output logic                  seq_num_acknack_o,
  output logic [7:0]            tx_fc_ph_o,
  output logic [7:0]            tx_fc_nph_o,
  output logic [7:0]            tx_fc_cplh_o,
  output logic [11:0]           tx_fc_pd_o,
  output logic [11:0]           tx_fc_npd_o,
  output logic [11:0]           tx_fc_cpld_o,
  output logic                  update_fc_o,
  output logic                  fc1_values_stored_o,
  output logic                  fc2_values_stored_o,
  output logic                  crc_err_o
);

  typedef enum logic [1:0] {ST_BEAT0, ST_BEAT1, ST_DROP} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_hdr;
  logic [2:0]  r_seen;
  logic        w_latch, w_eval, w_frm_err, w_crc_ok;
  logic        w_unused;

  assign s_axis_tready = rst_ni;
  assign w_unused = ^{s_axis_tkeep, s_axis_tuser, s_axis_tdata[DATA_WIDTH-1:16]};

`ifdef DLLP_CRC_CHECK_EN
  logic [15:0] r_crc_exp;

  // Returns the wire image {byte5, byte4}: complemented remainder, each byte bit-reversed.
  function automatic logic [15:0] dllp_crc(input logic [31:0] d);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[15] ^ d[8*b+k];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
      end
    end
    r = ~c;
    for (int k = 0; k < 8; k++) begin
      dllp_crc[k]   = r[15-k];
      dllp_crc[8+k] = r[7-k];
    end
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_crc_exp <= 16'h0000;
    end else if (w_latch) begin
      r_crc_exp <= dllp_crc(s_axis_tdata[31:0]);
    end
  end

  assign w_crc_ok = (s_axis_tdata[15:0] == r_crc_exp);
`else
  assign w_crc_ok = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_BEAT0;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BEAT0: if (s_axis_tvalid && !s_axis_tlast) w_state_nxt = ST_BEAT1;
      ST_BEAT1: if (s_axis_tvalid) w_state_nxt = s_axis_tlast ? ST_BEAT0 : ST_DROP;
      ST_DROP:  if (s_axis_tvalid && s_axis_tlast) w_state_nxt = ST_BEAT0;
      default:  w_state_nxt = ST_BEAT0;
    endcase
    if (!phy_link_up_i) w_state_nxt = ST_BEAT0;
  end

  always_comb begin
    w_latch   = 1'b0;
    w_eval    = 1'b0;
    w_frm_err = 1'b0;
    if (phy_link_up_i && s_axis_tvalid) begin
      case (r_state)
        ST_BEAT0: begin
          w_latch   = !s_axis_tlast;
          w_frm_err = s_axis_tlast;
        end
        ST_BEAT1: begin
          w_eval    = s_axis_tlast;
          w_frm_err = !s_axis_tlast;
        end
        default: ;
      endcase
    end
  end

  // Field decode of the latched beat 0.
  logic [7:0]  w_b0;
  logic [7:0]  w_hdrfc;
  logic [11:0] w_datafc;
  logic        w_vc0_fc, w_is_ack, w_is_nak;
  logic        w_fc1, w_fc2, w_upd;
  logic [2:0]  w_cls_oh;
  logic [2:0]  w_seen_nxt;

  assign w_b0     = r_hdr[7:0];
  assign w_hdrfc  = {r_hdr[13:8], r_hdr[23:22]};
  assign w_datafc = {r_hdr[19:16], r_hdr[31:24]};
  assign w_is_ack = (w_b0 == 8'h00);
  assign w_is_nak = (w_b0 == 8'h10);
  assign w_vc0_fc = (w_b0[3:0] == 4'h0) && (w_b0[5:4] != 2'b11);
  assign w_fc1    = w_vc0_fc && (w_b0[7:6] == 2'b01) && !fc2_values_stored_o;
  assign w_fc2    = w_vc0_fc && (w_b0[7:6] == 2'b11) && fc1_values_stored_o;
  assign w_upd    = w_vc0_fc && (w_b0[7:6] == 2'b10) && fc2_values_stored_o;
  assign w_cls_oh = 3'b001 << w_b0[5:4];
  assign w_seen_nxt = r_seen | w_cls_oh;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hdr               <= 32'h0;
      r_seen              <= 3'b000;
      seq_num_o           <= 12'h000;
      seq_num_vld_o       <= 1'b0;
      seq_num_acknack_o   <= 1'b0;
      tx_fc_ph_o          <= 8'h00;
      tx_fc_nph_o         <= 8'h00;
      tx_fc_cplh_o        <= 8'h00;
      tx_fc_pd_o          <= 12'h000;
      tx_fc_npd_o         <= 12'h000;
      tx_fc_cpld_o        <= 12'h000;
      update_fc_o         <= 1'b0;
      fc1_values_stored_o <= 1'b0;
      fc2_values_stored_o <= 1'b0;
      crc_err_o           <= 1'b0;
    end else begin
      seq_num_vld_o <= 1'b0;
      update_fc_o   <= 1'b0;
      crc_err_o     <= 1'b0;
      if (!phy_link_up_i) begin
        r_seen              <= 3'b000;
        seq_num_o           <= 12'h000;
        tx_fc_ph_o          <= 8'h00;
        tx_fc_nph_o         <= 8'h00;
        tx_fc_cplh_o        <= 8'h00;
        tx_fc_pd_o          <= 12'h000;
        tx_fc_npd_o         <= 12'h000;
        tx_fc_cpld_o        <= 12'h000;
        fc1_values_stored_o <= 1'b0;
        fc2_values_stored_o <= 1'b0;
      end else begin
        if (w_latch) r_hdr <= s_axis_tdata[31:0];
        if (w_frm_err || (w_eval && !w_crc_ok)) crc_err_o <= 1'b1;
        if (w_eval && w_crc_ok) begin
          if (w_is_ack || w_is_nak) begin
            seq_num_o         <= w_datafc;
            seq_num_acknack_o <= w_is_ack;
            seq_num_vld_o     <= 1'b1;
          end
          if (w_fc1 || w_upd) begin
            case (w_b0[5:4])
              2'b00: begin tx_fc_ph_o   <= w_hdrfc; tx_fc_pd_o   <= w_datafc; end
              2'b01: begin tx_fc_nph_o  <= w_hdrfc; tx_fc_npd_o  <= w_datafc; end
              default: begin tx_fc_cplh_o <= w_hdrfc; tx_fc_cpld_o <= w_datafc; end
            endcase
          end
          if (w_fc1) begin
            r_seen <= w_seen_nxt;
            if (&w_seen_nxt) fc1_values_stored_o <= 1'b1;
          end
          if (w_fc2) fc2_values_stored_o <= 1'b1;
          if (w_upd) update_fc_o <= 1'b1;
        end
      end
    end
  end

endmodule
